// File: rtl/memory_stage_stacked_if.sv
// Execute-to-memory operation bundle and memory-stage results for memory_stage_stacked.
// The execute side drives through the master modport and the stage implements the slave modport.
interface memory_stage_stacked_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int PC_WIDTH   = 32,
    parameter int FLAG_WIDTH = 3
);
    logic                  in_valid;
    logic                  memory_read;
    logic                  memory_write;
    logic                  memory_push;
    logic                  memory_pop;
    logic [1:0]            memory_address_select;
    logic [1:0]            memory_write_src_select;
    logic [DATA_WIDTH-1:0] std_address;
    logic [DATA_WIDTH-1:0] ldd_address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [PC_WIDTH-1:0]   pc;
    logic [FLAG_WIDTH-1:0] flags;

    logic [DATA_WIDTH-1:0] data_r;
    logic [PC_WIDTH-1:0]   pc_r;
    logic [FLAG_WIDTH-1:0] flags_r;
    logic                  out_valid;
    logic                  pc_valid;
    logic                  flags_valid;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] sp;
    logic                  stack_overflow;
    logic                  stack_underflow;

    modport master (
        output in_valid, memory_read, memory_write, memory_push, memory_pop,
               memory_address_select, memory_write_src_select,
               std_address, ldd_address, write_data, pc, flags,
        input  data_r, pc_r, flags_r, out_valid, pc_valid, flags_valid,
               stall, sp, stack_overflow, stack_underflow
    );

    modport slave (
        input  in_valid, memory_read, memory_write, memory_push, memory_pop,
               memory_address_select, memory_write_src_select,
               std_address, ldd_address, write_data, pc, flags,
        output data_r, pc_r, flags_r, out_valid, pc_valid, flags_valid,
               stall, sp, stack_overflow, stack_underflow
    );
endinterface

// File: rtl/memory_stage_stacked.sv
// Data-memory stage: single-word load/store plus multi-beat PC/flags push and pop on a
// full-descending stack, with registered results and a stall while a transfer is in flight.
module memory_stage_stacked #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int PC_WIDTH   = 32,
    parameter int FLAG_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] SP_INIT = {ADDR_WIDTH{1'b1}}
) (
    input  logic clk,
    input  logic reset,
    memory_stage_stacked_if.slave bus
);

    typedef enum logic {IDLE, XFER} state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  push_q, push_d;
    logic                  three_q, three_d;
    logic [DATA_WIDTH-1:0] pc_lo_hold_q, pc_lo_hold_d;
    logic [DATA_WIDTH-1:0] flags_hold_q, flags_hold_d;
    logic [DATA_WIDTH-1:0] pop_lo_q, pop_lo_d;
    logic [FLAG_WIDTH-1:0] pop_flags_q, pop_flags_d;
    logic [ADDR_WIDTH-1:0] sp_q, sp_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;
    logic                  out_valid_q, out_valid_d;
    logic                  pc_valid_q, pc_valid_d;
    logic                  flags_valid_q, flags_valid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    logic [ADDR_WIDTH-1:0] sp_inc, sp_dec;
    logic [DATA_WIDTH-1:0] sel_operand;
    logic [ADDR_WIDTH-1:0] op_addr;
    logic [1:0]            n_last;
    logic [1:0]            last_beat;
    logic                  stall;
    logic                  unused_addr_bits;

    assign sp_inc      = sp_q + ADDR_WIDTH'(1);
    assign sp_dec      = sp_q - ADDR_WIDTH'(1);
    assign sel_operand = (bus.memory_address_select == 2'b01) ? bus.ldd_address : bus.std_address;
    assign op_addr     = sel_operand[ADDR_WIDTH-1:0];
    assign rd_data     = mem[rd_addr];
    assign last_beat   = three_q ? 2'd2 : 2'd1;
    assign unused_addr_bits = ^{bus.std_address, bus.ldd_address};

    // Index of the final beat for the requested transfer length (0 = single word).
    always_comb begin
        unique case (bus.memory_write_src_select)
            2'b01:   n_last = 2'd1;
            2'b10:   n_last = 2'd2;
            default: n_last = 2'd0;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        push_d        = push_q;
        three_d       = three_q;
        pc_lo_hold_d  = pc_lo_hold_q;
        flags_hold_d  = flags_hold_q;
        pop_lo_d      = pop_lo_q;
        pop_flags_d   = pop_flags_q;
        sp_d          = sp_q;
        data_d        = data_q;
        pc_d          = pc_q;
        flags_d       = flags_q;
        out_valid_d   = 1'b0;
        pc_valid_d    = 1'b0;
        flags_valid_d = 1'b0;
        ovf_d         = ovf_q;
        unf_d         = unf_q;
        stall         = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = sp_q;
        mem_wdata     = bus.write_data;
        rd_addr       = sp_inc;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.memory_push) begin
                        mem_we    = 1'b1;
                        mem_wdata = (n_last == 2'd0) ? bus.write_data
                                                     : bus.pc[PC_WIDTH-1:DATA_WIDTH];
                        sp_d      = sp_dec;
                        if (sp_q == '0) ovf_d = 1'b1;
                        if (n_last != 2'd0) begin
                            state_d      = XFER;
                            cnt_d        = 2'd1;
                            push_d       = 1'b1;
                            three_d      = (n_last == 2'd2);
                            pc_lo_hold_d = bus.pc[DATA_WIDTH-1:0];
                            flags_hold_d = '0;
                            flags_hold_d[FLAG_WIDTH-1:0] = bus.flags;
                            stall        = 1'b1;
                        end
                    end else if (bus.memory_pop) begin
                        sp_d = sp_inc;
                        if (sp_q == '1) unf_d = 1'b1;
                        if (n_last == 2'd0) begin
                            data_d      = rd_data;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = XFER;
                            cnt_d   = 2'd1;
                            push_d  = 1'b0;
                            three_d = (n_last == 2'd2);
                            // First popped word is flags for a 3-beat pop, PC low otherwise.
                            if (n_last == 2'd2) pop_flags_d = rd_data[FLAG_WIDTH-1:0];
                            else                pop_lo_d    = rd_data;
                            stall   = 1'b1;
                        end
                    end else if (bus.memory_read) begin
                        rd_addr     = op_addr;
                        data_d      = rd_data;
                        out_valid_d = 1'b1;
                    end else if (bus.memory_write) begin
                        mem_we    = 1'b1;
                        mem_waddr = op_addr;
                    end
                end
            end

            XFER: begin
                stall = (cnt_q != last_beat);
                if (push_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = (cnt_q == 2'd1) ? pc_lo_hold_q : flags_hold_q;
                    sp_d      = sp_dec;
                    if (sp_q == '0) ovf_d = 1'b1;
                end else begin
                    sp_d = sp_inc;
                    if (sp_q == '1) unf_d = 1'b1;
                    if (cnt_q == last_beat) begin
                        pc_d        = {rd_data, pop_lo_q};
                        out_valid_d = 1'b1;
                        pc_valid_d  = 1'b1;
                        if (three_q) begin
                            flags_d       = pop_flags_q;
                            flags_valid_d = 1'b1;
                        end
                    end else begin
                        pop_lo_d = rd_data;
                    end
                end
                if (cnt_q == last_beat) begin
                    state_d = IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the array has no reset; contents survive reset and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we && reset) mem[mem_waddr] <= mem_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= 2'd0;
            push_q        <= 1'b0;
            three_q       <= 1'b0;
            pc_lo_hold_q  <= '0;
            flags_hold_q  <= '0;
            pop_lo_q      <= '0;
            pop_flags_q   <= '0;
            sp_q          <= SP_INIT;
            data_q        <= '0;
            pc_q          <= '0;
            flags_q       <= '0;
            out_valid_q   <= 1'b0;
            pc_valid_q    <= 1'b0;
            flags_valid_q <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            push_q        <= push_d;
            three_q       <= three_d;
            pc_lo_hold_q  <= pc_lo_hold_d;
            flags_hold_q  <= flags_hold_d;
            pop_lo_q      <= pop_lo_d;
            pop_flags_q   <= pop_flags_d;
            sp_q          <= sp_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
            flags_q       <= flags_d;
            out_valid_q   <= out_valid_d;
            pc_valid_q    <= pc_valid_d;
            flags_valid_q <= flags_valid_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
        end
    end

    assign bus.data_r          = data_q;
    assign bus.pc_r            = pc_q;
    assign bus.flags_r         = flags_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.pc_valid        = pc_valid_q;
    assign bus.flags_valid     = flags_valid_q;
    assign bus.stall           = stall;
    assign bus.sp              = sp_q;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;

endmodule

// File: tb/tb_memory_stage_stacked.sv
// Directed bench for memory_stage_stacked: load/store, PC and PC+flags push/pop,
// stack wrap flags and reset during a multi-beat push.
module tb_memory_stage_stacked;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    memory_stage_stacked_if #(
        .DATA_WIDTH(16), .ADDR_WIDTH(11), .PC_WIDTH(32), .FLAG_WIDTH(3)
    ) bus ();

    memory_stage_stacked #(
        .DATA_WIDTH(16), .ADDR_WIDTH(11), .PC_WIDTH(32), .FLAG_WIDTH(3),
        .SP_INIT(11'h7FF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic rd, input logic wr, input logic ps, input logic pp,
                      input logic [1:0] asel, input logic [1:0] src);
        bus.in_valid                = rd | wr | ps | pp;
        bus.memory_read             = rd;
        bus.memory_write            = wr;
        bus.memory_push             = ps;
        bus.memory_pop              = pp;
        bus.memory_address_select   = asel;
        bus.memory_write_src_select = src;
        #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus.std_address = '0;
        bus.ldd_address = '0;
        bus.write_data  = '0;
        bus.pc          = '0;
        bus.flags       = '0;
        idle();
        tick();
        tick();

        check("rst_data_r", 32'(bus.data_r), 32'h0);
        check("rst_pc_r", bus.pc_r, 32'h0);
        check("rst_flags_r", 32'(bus.flags_r), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_sp", 32'(bus.sp), 32'h7FF);
        check("rst_ovf", 32'(bus.stack_overflow), 32'h0);
        check("rst_unf", 32'(bus.stack_underflow), 32'h0);
        reset = 1'b1;
        tick();

        // Store then load through std_address.
        bus.std_address = 16'h0010;
        bus.write_data  = 16'hBEEF;
        op(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        check("wr_stall", 32'(bus.stall), 32'h0);
        tick();
        op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("rd_data", 32'(bus.data_r), 32'hBEEF);
        check("rd_out_valid", 32'(bus.out_valid), 32'h1);
        check("rd_pc_valid", 32'(bus.pc_valid), 32'h0);
        idle();
        tick();
        check("rd_out_valid_pulse", 32'(bus.out_valid), 32'h0);

        // ldd operand with upper bits set; read back via std.
        bus.ldd_address = 16'h0820;
        bus.write_data  = 16'h1111;
        op(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00);
        tick();
        bus.std_address = 16'h0020;
        op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("ldd_wr_rd", 32'(bus.data_r), 32'h1111);

        // Read outranks write: the write to 0x10 must be dropped.
        bus.std_address = 16'h0010;
        bus.write_data  = 16'hDEAD;
        op(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("prio_rd", 32'(bus.data_r), 32'hBEEF);
        op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("prio_wr_dropped", 32'(bus.data_r), 32'hBEEF);
        idle();
        tick();

        // Two-beat PC push followed immediately by a two-beat pop.
        bus.pc = 32'h1234_5678;
        op(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01);
        check("push2_stall_accept", 32'(bus.stall), 32'h1);
        tick();
        check("push2_sp_beat0", 32'(bus.sp), 32'h7FE);
        bus.pc = 32'h0;
        op(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01);
        check("push2_stall_last", 32'(bus.stall), 32'h0);
        tick();
        check("push2_sp", 32'(bus.sp), 32'h7FD);
        check("pop2_stall_accept", 32'(bus.stall), 32'h1);
        tick();
        check("pop2_stall_last", 32'(bus.stall), 32'h0);
        idle();
        tick();
        check("pop2_pc_r", bus.pc_r, 32'h1234_5678);
        check("pop2_out_valid", 32'(bus.out_valid), 32'h1);
        check("pop2_pc_valid", 32'(bus.pc_valid), 32'h1);
        check("pop2_flags_valid", 32'(bus.flags_valid), 32'h0);
        check("pop2_sp", 32'(bus.sp), 32'h7FF);
        check("pop2_unf", 32'(bus.stack_underflow), 32'h0);

        // Three-beat PC+flags push and pop.
        bus.pc    = 32'hCAFE_0001;
        bus.flags = 3'b101;
        op(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
        check("push3_stall_c0", 32'(bus.stall), 32'h1);
        tick();
        check("push3_stall_c1", 32'(bus.stall), 32'h1);
        bus.pc    = 32'h0;
        bus.flags = 3'b000;
        idle();
        tick();
        check("push3_stall_c2", 32'(bus.stall), 32'h0);
        tick();
        check("push3_sp", 32'(bus.sp), 32'h7FC);
        op(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10);
        check("pop3_stall_c0", 32'(bus.stall), 32'h1);
        tick();
        check("pop3_stall_c1", 32'(bus.stall), 32'h1);
        idle();
        tick();
        check("pop3_stall_c2", 32'(bus.stall), 32'h0);
        check("pop3_out_valid_early", 32'(bus.out_valid), 32'h0);
        tick();
        check("pop3_pc_r", bus.pc_r, 32'hCAFE_0001);
        check("pop3_flags_r", 32'(bus.flags_r), 32'h5);
        check("pop3_flags_valid", 32'(bus.flags_valid), 32'h1);
        check("pop3_pc_valid", 32'(bus.pc_valid), 32'h1);
        check("pop3_sp", 32'(bus.sp), 32'h7FF);
        tick();
        check("pop3_out_valid_pulse", 32'(bus.out_valid), 32'h0);

        // Single-word push, then pop with src=11 (single word).
        bus.write_data = 16'hA5A5;
        op(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        check("push1_stall", 32'(bus.stall), 32'h0);
        tick();
        check("push1_sp", 32'(bus.sp), 32'h7FE);
        op(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11);
        tick();
        check("pop1_data_r", 32'(bus.data_r), 32'hA5A5);
        check("pop1_pc_valid", 32'(bus.pc_valid), 32'h0);
        check("pop1_pc_r_kept", bus.pc_r, 32'hCAFE_0001);
        check("pop1_sp", 32'(bus.sp), 32'h7FF);

        // Pop at the top wraps to 0 and reads mem[0].
        bus.std_address = 16'h0000;
        bus.write_data  = 16'h0F0F;
        op(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        op(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        check("unf_sp", 32'(bus.sp), 32'h0);
        check("unf_data_r", 32'(bus.data_r), 32'h0F0F);
        check("unf_flag", 32'(bus.stack_underflow), 32'h1);

        // Push at sp=0 wraps to the top and flags overflow.
        bus.write_data = 16'h7777;
        op(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        tick();
        check("wrap_push_sp", 32'(bus.sp), 32'h7FF);
        check("wrap_push_ovf", 32'(bus.stack_overflow), 32'h1);
        check("unf_sticky", 32'(bus.stack_underflow), 32'h1);
        bus.std_address = 16'h0000;
        op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("wrap_push_mem0", 32'(bus.data_r), 32'h7777);
        check("unf_sticky2", 32'(bus.stack_underflow), 32'h1);

        // 2048 single-word pushes from reset: overflow on the last one.
        idle();
        reset = 1'b0;
        #1;
        check("rst2_ovf", 32'(bus.stack_overflow), 32'h0);
        check("rst2_unf", 32'(bus.stack_underflow), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        bus.write_data = 16'h3C3C;
        op(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        repeat (2047) tick();
        check("ovf_2047_sp", 32'(bus.sp), 32'h0);
        check("ovf_2047_flag", 32'(bus.stack_overflow), 32'h0);
        tick();
        check("ovf_2048_flag", 32'(bus.stack_overflow), 32'h1);
        check("ovf_2048_sp", 32'(bus.sp), 32'h7FF);
        idle();
        tick();

        // Reset after beat 1 of a three-beat push.
        bus.pc    = 32'h5555_AAAA;
        bus.flags = 3'b011;
        op(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
        tick();
        idle();
        tick();
        reset = 1'b0;
        #1;
        check("abort_sp", 32'(bus.sp), 32'h7FF);
        check("abort_stall", 32'(bus.stall), 32'h0);
        check("abort_data_r", 32'(bus.data_r), 32'h0);
        check("abort_pc_r", bus.pc_r, 32'h0);
        check("abort_flags_r", 32'(bus.flags_r), 32'h0);
        check("abort_out_valid", 32'(bus.out_valid), 32'h0);
        check("abort_ovf", 32'(bus.stack_overflow), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        bus.std_address = 16'hF7FF;
        op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("abort_mem2047", 32'(bus.data_r), 32'h5555);
        bus.std_address = 16'h07FE;
        op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        tick();
        check("abort_mem2046", 32'(bus.data_r), 32'hAAAA);
        check("abort_state_idle", 32'(bus.stall), 32'h0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage_stacked.md
Name: memory_stage_stacked

Overview:
Parameterised data-memory stage for the pipelined RISC core, placed between execute and write-back. It holds the data memory and the stack pointer. It performs single-word load/store and multi-beat push/pop of PC and flags for CALL/RET/INT/RTI. Results are registered. The stage raises stall to the hazard unit while a multi-beat transfer is in progress.

Parameters:
DATA_WIDTH, 16, memory word and data path width
ADDR_WIDTH, 11, memory address width; depth = 2**ADDR_WIDTH words
PC_WIDTH, 32, program counter width; must equal 2*DATA_WIDTH
FLAG_WIDTH, 3, flag vector width; must be <= DATA_WIDTH
SP_INIT, 2**ADDR_WIDTH-1, stack pointer value after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  the presented operation is valid this cycle
memory_read  in  1  load one word from the selected address
memory_write  in  1  store write_data to the selected address
memory_push  in  1  push; length is set by memory_write_src_select
memory_pop  in  1  pop; length is set by memory_write_src_select
memory_address_select  in  2  00 std_address, 01 ldd_address, 1x reserved (treated as 00)
memory_write_src_select  in  2  00 one data word, 01 PC (2 words), 10 PC+flags (3 words), 11 treated as 00
std_address  in  DATA_WIDTH  address operand (read data1)
ldd_address  in  DATA_WIDTH  address operand (load displacement)
write_data  in  DATA_WIDTH  store/push data
pc  in  PC_WIDTH  PC to push
flags  in  FLAG_WIDTH  flags to push
data_r  out  DATA_WIDTH  registered load/pop word
pc_r  out  PC_WIDTH  registered popped PC
flags_r  out  FLAG_WIDTH  registered popped flags
out_valid  out  1  one-cycle pulse: a read or pop has completed
pc_valid  out  1  with out_valid: pc_r was updated
flags_valid  out  1  with out_valid: flags_r was updated
stall  out  1  combinational; the stage is busy and upstream must hold
sp  out  ADDR_WIDTH  current stack pointer
stack_overflow  out  1  sticky
stack_underflow  out  1  sticky

Behaviour:
- Reset (asynchronous, active-low):
  - data_r, pc_r and flags_r are 0.
  - out_valid, pc_valid, flags_valid, stall, stack_overflow and stack_underflow are 0.
  - sp is SP_INIT and the FSM is in IDLE.
  - Memory array contents are not cleared.
  - Reset asserted mid-transfer aborts the transfer; beats already written stay in memory.
- Address: the low ADDR_WIDTH bits of the selected operand are used; upper bits are ignored.
- Memory: synchronous write, combinational read; the read result is captured into the output registers at the edge.
- Operation decode:
  - An operation is accepted only when in_valid=1 and the FSM is in IDLE.
  - Priority when several strobes are high: push > pop > read > write; lower-priority strobes are ignored.
- Stack model: full-descending.
  - Push beat: mem[sp] <= word, then sp <= sp-1.
  - Pop beat: sp <= sp+1, then word <= mem[sp+1].
- Push order: pc[PC_WIDTH-1:DATA_WIDTH] first, then pc[DATA_WIDTH-1:0], then flags zero-extended to DATA_WIDTH (3-beat case only).
- Pop order is the reverse: flags, then PC low, then PC high.
- Single-word read or write:
  - 1 cycle, stall=0.
  - Read: data_r is updated and out_valid=1 in the cycle after acceptance.
- Multi-beat push/pop with N in {2,3} beats:
  - FSM: IDLE -> XFER (beat counter 0..N-1) -> IDLE.
  - Beat 0 executes in the accept cycle.
  - stall=1 from the accept cycle through beat N-2, and 0 on the last beat.
  - Pop: pc_r/flags_r are updated at the last beat's edge; out_valid, pc_valid and flags_valid (3-beat only) pulse for 1 cycle after it.
  - A 1-word pop updates data_r only.
- Inputs are ignored while in XFER; upstream holds them stable under stall.
- Wrap-around:
  - A push beat at sp=0 writes mem[0], wraps sp to 2**ADDR_WIDTH-1 and sets stack_overflow.
  - A pop beat at sp=2**ADDR_WIDTH-1 wraps sp to 0, reads mem[0] and sets stack_underflow.
  - Both flags clear only on reset.
- A new operation may be accepted in the cycle immediately after the last beat; out_valid of the prior pop coincides with it.

Test Plan:
- Reset, then write write_data=16'hBEEF to std_address=16'h0010 and read it back -> data_r=16'hBEEF, out_valid pulses 1 cycle after the read.
- Push with src=01, pc=32'h1234_5678 -> stall=1 for 1 cycle; mem[2047]=16'h1234, mem[2046]=16'h5678; sp=2045.
- Pop with src=01 immediately after the push -> pc_r=32'h1234_5678, pc_valid=1, flags_valid=0, sp=2047, no underflow.
- Push with src=10, pc=32'hCAFE_0001, flags=3'b101, then pop with src=10 -> stall high 2 cycles each; flags_r=3'b101, pc_r=32'hCAFE_0001, flags_valid=1.
- Pop at sp=2047 -> sp=0, stack_underflow=1 and it stays 1; 2048 single-word pushes from reset -> stack_overflow=1 on the 2048th push.
- Assert reset mid 3-beat push after beat 1 -> sp=SP_INIT, stall=0, all outputs 0; the next read of mem[2047] returns the beat-0 word.
